// File: rtl/eth_tx_pad.sv
// Transmit payload buffer: collects handler bytes into one frame, then replays it to the MAC.
// Optional minimum-length zero padding is compiled in with `define TX_MIN_PAD_EN.
module eth_tx_pad #(
    parameter int MAX_PAYLOAD = 1500,
    parameter int MIN_PAYLOAD = 46,
    parameter int GAP_CYCLES  = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_wdata,
    input  logic        i_wvalid,
    output logic        o_wready,
    output logic [7:0]  o_tdata,
    output logic        o_tvalid,
    input  logic        i_tready,
    output logic        o_tlast,
    output logic        o_busy,
    output logic [10:0] o_frame_len
);

    // Stream handshake: a byte moves when o_tvalid && i_tready on a rising edge;
    // while o_tvalid && !i_tready, o_tdata/o_tlast hold and o_tvalid stays high.

    localparam logic [10:0] MAX_L = 11'(MAX_PAYLOAD);
    localparam logic [10:0] MIN_L = 11'(MIN_PAYLOAD);
    localparam logic [7:0]  GAP_L = 8'(GAP_CYCLES);
`ifdef TX_MIN_PAD_EN
    localparam logic PAD_EN = 1'b1;
`else
    localparam logic PAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FETCH   = 2'd1,
        DRAIN   = 2'd2,
        PAD     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] wr_cnt_q, wr_cnt_d;
    logic [10:0] rd_cnt_q, rd_cnt_d;
    logic [7:0]  idle_q, idle_d;
    logic [10:0] frame_len_q, frame_len_d;
`ifdef TX_MIN_PAD_EN
    logic [10:0] pad_cnt_q, pad_cnt_d;
`endif

    logic [7:0]  mem [MAX_PAYLOAD];
    logic [7:0]  rdata_q;
    logic [10:0] rd_addr;
    logic        accept;
    logic        last_stored;
    logic        pad_needed;

    assign pad_needed  = PAD_EN && (frame_len_q < MIN_L);
    assign last_stored = (rd_cnt_q == frame_len_q - 11'd1);
    assign o_busy      = (state_q != COLLECT);
    assign o_frame_len = frame_len_q;

    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        idle_d      = idle_q;
        frame_len_d = frame_len_q;
`ifdef TX_MIN_PAD_EN
        pad_cnt_d   = pad_cnt_q;
`endif
        accept      = 1'b0;
        o_wready    = 1'b0;
        o_tvalid    = 1'b0;
        o_tlast     = 1'b0;
        o_tdata     = 8'h00;

        case (state_q)
            COLLECT: begin
                o_wready = 1'b1;
                accept   = i_wvalid;
                rd_cnt_d = 11'd0;
                if (accept) begin
                    // An accept always wins over a simultaneous gap expiry.
                    wr_cnt_d = wr_cnt_q + 11'd1;
                    idle_d   = 8'd0;
                    if (wr_cnt_d == MAX_L) begin
                        frame_len_d = wr_cnt_d;
                        state_d     = FETCH;
                    end
                end else if (wr_cnt_q != 11'd0) begin
                    if (idle_q == GAP_L) begin
                        frame_len_d = wr_cnt_q;
                        state_d     = FETCH;
                    end else begin
                        idle_d = idle_q + 8'd1;
                    end
                end
            end
            FETCH: begin
                rd_cnt_d = 11'd0;
                state_d  = DRAIN;
            end
            DRAIN: begin
                o_tvalid = 1'b1;
                o_tdata  = rdata_q;
                o_tlast  = last_stored && !pad_needed;
                if (i_tready) begin
                    if (!last_stored) begin
                        rd_cnt_d = rd_cnt_q + 11'd1;
                    end else if (pad_needed) begin
`ifdef TX_MIN_PAD_EN
                        pad_cnt_d = MIN_L - frame_len_q;
`endif
                        state_d   = PAD;
                    end else begin
                        state_d  = COLLECT;
                        wr_cnt_d = 11'd0;
                        rd_cnt_d = 11'd0;
                        idle_d   = 8'd0;
                    end
                end
            end
`ifdef TX_MIN_PAD_EN
            PAD: begin
                o_tvalid = 1'b1;
                o_tlast  = (pad_cnt_q == 11'd1);
                if (i_tready) begin
                    if (pad_cnt_q == 11'd1) begin
                        state_d  = COLLECT;
                        wr_cnt_d = 11'd0;
                        rd_cnt_d = 11'd0;
                        idle_d   = 8'd0;
                    end else begin
                        pad_cnt_d = pad_cnt_q - 11'd1;
                    end
                end
            end
`endif
            default: state_d = COLLECT;
        endcase

        // Read the next cycle's byte so o_tdata is ready without a bubble.
        rd_addr = rd_cnt_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= COLLECT;
            wr_cnt_q    <= 11'd0;
            rd_cnt_q    <= 11'd0;
            idle_q      <= 8'd0;
            frame_len_q <= 11'd0;
`ifdef TX_MIN_PAD_EN
            pad_cnt_q   <= 11'd0;
`endif
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            idle_q      <= idle_d;
            frame_len_q <= frame_len_d;
`ifdef TX_MIN_PAD_EN
            pad_cnt_q   <= pad_cnt_d;
`endif
        end
    end

    // Payload RAM: no reset, output register only seen through DRAIN.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem[wr_cnt_q] <= i_wdata;
        end
        if (rd_addr < MAX_L) begin
            rdata_q <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_eth_tx_pad.sv
// Bench for eth_tx_pad: frame-level queue model checked every cycle, plus directed literal checks.
module tb_eth_tx_pad;
  localparam int MAXP = 1500;
  localparam int MINP = 46;
  localparam int GAP  = 16;
`ifdef TX_MIN_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  wdata = 8'h00;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic        busy;
  logic [10:0] frame_len;

  always #5 clk = ~clk;

  eth_tx_pad #(.MAX_PAYLOAD(MAXP), .MIN_PAYLOAD(MINP), .GAP_CYCLES(GAP)) dut (
    .i_clk(clk), .i_rst(rst), .i_wdata(wdata), .i_wvalid(wvalid), .o_wready(wready),
    .o_tdata(tdata), .o_tvalid(tvalid), .i_tready(tready), .o_tlast(tlast),
    .o_busy(busy), .o_frame_len(frame_len)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: phase 0 = collecting, 1 = frame closed / fetching, 2 = streaming exp_q
  int         m_phase;
  int         m_idle;
  int         m_len;
  logic [7:0] m_buf[$];
  logic [8:0] exp_q[$];

  int         cyc = 0;
  int         last_acc_cyc = 0;
  int         first_valid_cyc = 0;
  int         cap_len = 0;
  int         frames_done = 0;
  logic [7:0] got_q[$];
  logic       prev_stall = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;
  logic       rand_ready = 1'b0;

  task automatic model_reset();
    m_phase = 0;
    m_idle  = 0;
    m_len   = 0;
    m_buf.delete();
    exp_q.delete();
  endtask

  task automatic model_close();
    int total;
    total = m_buf.size();
    if (PAD_ON && total < MINP) total = MINP;
    exp_q.delete();
    for (int i = 0; i < total; i++) begin
      logic [7:0] d;
      d = (i < m_buf.size()) ? m_buf[i] : 8'h00;
      exp_q.push_back({(i == total - 1), d});
    end
    m_len = m_buf.size();
    m_buf.delete();
    m_phase = 1;
  endtask

  task automatic model_step();
    case (m_phase)
      0: begin
        if (wvalid) begin
          m_buf.push_back(wdata);
          m_idle = 0;
          last_acc_cyc = cyc;
          if (m_buf.size() == MAXP) model_close();
        end else if (m_buf.size() > 0) begin
          if (m_idle == GAP) model_close();
          else m_idle++;
        end
      end
      1: m_phase = 2;
      default: begin
        if (tready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            m_phase = 0;
            m_idle  = 0;
          end
        end
      end
    endcase
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      model_reset();
      prev_stall = 1'b0;
      prev_valid = 1'b0;
      check("rst_wready", 32'(wready), 32'd1);
      check("rst_tvalid", 32'(tvalid), 32'd0);
      check("rst_tlast", 32'(tlast), 32'd0);
      check("rst_tdata", 32'(tdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_len", 32'(frame_len), 32'd0);
    end else begin
      check("wready", 32'(wready), 32'(m_phase == 0));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("tvalid", 32'(tvalid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        check("tdata", 32'(tdata), 32'(exp_q[0][7:0]));
        check("tlast", 32'(tlast), 32'(exp_q[0][8]));
      end else begin
        check("tlast_idle", 32'(tlast), 32'd0);
      end
      if (m_phase != 0) check("frame_len", 32'(frame_len), 32'(m_len));
      if (prev_stall) begin
        check("stall_tvalid", 32'(tvalid), 32'd1);
        check("stall_tdata", 32'(tdata), 32'(prev_data));
        check("stall_tlast", 32'(tlast), 32'(prev_last));
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      if (tvalid && !prev_valid) begin
        first_valid_cyc = cyc;
        cap_len = int'(frame_len);
      end
      prev_valid = tvalid;
      if (tvalid && tready) begin
        got_q.push_back(tdata);
        if (tlast) frames_done++;
      end
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic write_byte(input logic [7:0] d);
    int k = 0;
    wdata  = d;
    wvalid = 1'b1;
    while (!wready && k < 5000) begin
      tick();
      k++;
    end
    tick();
    wvalid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int bound);
    int k = 0;
    while (frames_done < target && k < bound) begin
      tick();
      k++;
    end
    check("frame_timeout", 32'(frames_done >= target), 32'd1);
  endtask

  initial begin
    logic [7:0] sent_q[$];
    int mism;
    int k;

    idle(3);
    rst = 1'b0;
    idle(3);

    // 10-byte frame, padded to 46 when padding is built in
    got_q.delete();
    for (int i = 1; i <= 10; i++) write_byte(8'(i));
    wait_frames(1, 200);
    check("t1_count", 32'(got_q.size()), PAD_ON ? 32'd46 : 32'd10);
    mism = 0;
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] !== ((i < 10) ? 8'(i + 1) : 8'h00)) mism++;
    check("t1_payload", 32'(mism), 32'd0);
    check("t1_byte10", 32'(got_q[9]), 32'h0A);
    check("t1_frame_len", 32'(cap_len), 32'd10);
    check("t1_latency", 32'(first_valid_cyc - last_acc_cyc), 32'd19);

    // Maximum payload, back to back
    got_q.delete();
    sent_q.delete();
    for (int i = 0; i < MAXP; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      sent_q.push_back(d);
      write_byte(d);
    end
    check("t2_wready_low", 32'(wready), 32'd0);
    wait_frames(2, 4000);
    check("t2_count", 32'(got_q.size()), 32'd1500);
    mism = 0;
    for (int i = 0; i < MAXP; i++) if (got_q[i] !== sent_q[i]) mism++;
    check("t2_order", 32'(mism), 32'd0);
    check("t2_frame_len", 32'(cap_len), 32'd1500);

    // 60-byte frame drained with random back-pressure
    got_q.delete();
    sent_q.delete();
    for (int i = 0; i < 60; i++) begin
      sent_q.push_back(8'(i * 3 + 7));
      write_byte(8'(i * 3 + 7));
    end
    rand_ready = 1'b1;
    wait_frames(3, 2000);
    rand_ready = 1'b0;
    tready = 1'b1;
    check("t3_count", 32'(got_q.size()), 32'd60);
    mism = 0;
    for (int i = 0; i < 60; i++) if (got_q[i] !== sent_q[i]) mism++;
    check("t3_order", 32'(mism), 32'd0);

    // Gaps just under the limit, then a byte on the exact expiry cycle
    got_q.delete();
    write_byte(8'hA0);
    for (int i = 1; i < 5; i++) begin
      idle(15);
      write_byte(8'(8'hA0 + i));
    end
    idle(16);
    write_byte(8'hA5);
    wait_frames(4, 300);
    idle(5);
    check("t4_frames", 32'(frames_done), 32'd4);
    check("t4_frame_len", 32'(cap_len), 32'd6);
    check("t4_count", 32'(got_q.size()), PAD_ON ? 32'd46 : 32'd6);
    check("t4_last_stored", 32'(got_q[5]), 32'hA5);

    // Reset in the middle of DRAIN
    got_q.delete();
    for (int i = 0; i < 20; i++) write_byte(8'(8'h50 + i));
    k = 0;
    while (got_q.size() < 5 && k < 200) begin
      tick();
      k++;
    end
    check("t5_reached_drain", 32'(got_q.size() >= 5), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_imm_tvalid", 32'(tvalid), 32'd0);
    check("t5_imm_wready", 32'(wready), 32'd1);
    check("t5_imm_busy", 32'(busy), 32'd0);
    check("t5_imm_frame_len", 32'(frame_len), 32'd0);
    tick();
    rst = 1'b0;
    idle(40);
    check("t5_no_partial", 32'(frames_done), 32'd4);
    got_q.delete();
    for (int i = 0; i < 3; i++) write_byte(8'(8'hC1 + i));
    wait_frames(5, 200);
    check("t5_count", 32'(got_q.size()), PAD_ON ? 32'd46 : 32'd3);
    check("t5_frame_len", 32'(cap_len), 32'd3);
    check("t5_first", 32'(got_q[0]), 32'hC1);

    // Random frames, gaps and back-pressure, checked by the model every cycle
    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(1, 80);
      for (int i = 0; i < n; i++) begin
        write_byte(8'($urandom));
        idle($urandom_range(0, 20));
      end
    end
    rand_ready = 1'b0;
    tready = 1'b1;
    k = 0;
    while (!(m_phase == 0 && m_buf.size() == 0) && k < 3000) begin
      tick();
      k++;
    end
    check("t6_drained", 32'(m_phase == 0 && m_buf.size() == 0), 32'd1);
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
